// File: rtl/demux8_dispatch.sv
// 1-to-8 valid/ready dispatcher: each input word goes to one output channel,
// chosen by an explicit select or a round-robin pointer. Each channel has a one-entry holding register.
module demux8_dispatch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic             auto,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [2:0]       ptr
);

  logic [WIDTH-1:0] chan_data_p0 [8];
  logic [7:0]       vld_p0;
  logic [2:0]       ptr_p0;
  logic [2:0]       dest;
  logic             accept;

  // Only the destination channel decides whether a word can enter, so a stalled
  // round-robin target blocks input even when other channels are empty.
  always_comb begin
    dest     = auto ? ptr_p0 : in_sel;
    in_ready = !rst && (!vld_p0[dest] || out_ready[dest]);
    accept   = in_valid && in_ready;
  end

  // Stage p0: channel holding registers and the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 8'h00;
      ptr_p0 <= 3'd0;
      for (int i = 0; i < 8; i++) chan_data_p0[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept && (dest == 3'(i))) begin
          chan_data_p0[i] <= in_data;
          vld_p0[i]       <= 1'b1;
        end else if (out_ready[i]) begin
          vld_p0[i]       <= 1'b0;
        end
      end
      if (accept && auto) ptr_p0 <= ptr_p0 + 3'd1;
    end
  end

  assign out1      = chan_data_p0[0];
  assign out2      = chan_data_p0[1];
  assign out3      = chan_data_p0[2];
  assign out4      = chan_data_p0[3];
  assign out5      = chan_data_p0[4];
  assign out6      = chan_data_p0[5];
  assign out7      = chan_data_p0[6];
  assign out8      = chan_data_p0[7];
  assign out_valid = vld_p0;
  assign ptr       = ptr_p0;

endmodule

// File: tb/tb_demux8_dispatch.sv
// Directed self-checking bench for demux8_dispatch with an 8-bit payload.
module tb_demux8_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic       auto;
  logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [2:0] ptr;
  logic [7:0] outs [8];

  int checks   = 0;
  int failures = 0;

  demux8_dispatch #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_sel(in_sel), .auto(auto),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7), .out8(out8),
    .out_valid(out_valid), .out_ready(out_ready), .ptr(ptr)
  );

  always #5 clk = ~clk;

  assign outs[0] = out1; assign outs[1] = out2; assign outs[2] = out3; assign outs[3] = out4;
  assign outs[4] = out5; assign outs[5] = out6; assign outs[6] = out7; assign outs[7] = out8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_sel = 3'd0;
    auto = 1'b0; out_ready = 8'h00;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_ptr", ptr, 0);
    chk("rst_out1", out1, 0);
    rst = 1'b0;
    #1 chk("idle_in_ready", in_ready, 1);

    // select mode
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 3'd0;
    tick();
    chk("sel_out1", out1, 8'hA5);
    chk("sel_valid_a", out_valid, 8'h01);
    in_data = 8'h3C; in_sel = 3'd7;
    tick();
    chk("sel_out8", out8, 8'h3C);
    chk("sel_valid_b", out_valid, 8'h81);
    chk("sel_ptr", ptr, 0);

    // back-pressure on channel 2
    in_data = 8'h22; in_sel = 3'd2;
    tick();
    chk("bp_fill", out_valid, 8'h85);
    in_data = 8'h99;
    #1 chk("bp_in_ready_blk", in_ready, 0);
    tick();
    chk("bp_out3_hold", out3, 8'h22);
    chk("bp_valid_hold", out_valid, 8'h85);
    in_data = 8'h33; in_sel = 3'd3;
    #1 chk("bp_in_ready_other", in_ready, 1);
    tick();
    chk("bp_out4", out4, 8'h33);
    chk("bp_valid_c", out_valid, 8'h8D);

    // simultaneous drain and refill on channel 5
    in_data = 8'h55; in_sel = 3'd5;
    tick();
    chk("dr_fill", out6, 8'h55);
    out_ready = 8'h20; in_data = 8'h11;
    #1 chk("dr_in_ready", in_ready, 1);
    tick();
    chk("dr_valid5", out_valid[5], 1);
    chk("dr_out6", out6, 8'h11);
    for (int k = 0; k < 8; k++) begin
      in_data = 8'h20 + 8'(k);
      tick();
      chk($sformatf("dr_stream_data%0d", k), out6, 8'h20 + 8'(k));
      chk($sformatf("dr_stream_vld%0d", k), out_valid[5], 1);
    end
    in_valid = 1'b0;
    tick();
    chk("dr_drained", out_valid, 8'h8D);

    // round-robin wrap
    out_ready = 8'hFF;
    tick();
    chk("rr_empty", out_valid, 8'h00);
    auto = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'(k);
      #1 chk($sformatf("rr_ptr%0d", k), ptr, k % 8);
      tick();
      chk($sformatf("rr_data%0d", k), outs[k % 8], k);
      chk($sformatf("rr_vld%0d", k), out_valid, 32'(1) << (k % 8));
    end
    chk("rr_ptr_end", ptr, 2);

    // round-robin stall at channel 4
    in_data = 8'hB2; tick();
    in_data = 8'hB3; tick();
    chk("st_ptr4", ptr, 4);
    auto = 1'b0; in_sel = 3'd4; in_data = 8'h44; out_ready = 8'hEF;
    tick();
    chk("st_ptr_hold_sel", ptr, 4);
    in_valid = 1'b0;
    tick();
    chk("st_only4", out_valid, 8'h10);
    auto = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1 chk("st_in_ready_blk", in_ready, 0);
    tick();
    chk("st_ptr_stuck", ptr, 4);
    chk("st_out5_hold", out5, 8'h44);
    out_ready = 8'hFF;
    #1 chk("st_in_ready_rel", in_ready, 1);
    tick();
    chk("st_ptr5", ptr, 5);
    chk("st_out5_new", out5, 8'h77);
    in_valid = 1'b0;
    tick();

    // reset mid-stream
    out_ready = 8'h00; auto = 1'b0; in_valid = 1'b1;
    in_sel = 3'd0; in_data = 8'hA0; tick();
    in_sel = 3'd3; in_data = 8'hA3; tick();
    in_sel = 3'd6; in_data = 8'hA6; tick();
    chk("mr_valid", out_valid, 8'h49);
    chk("mr_ptr", ptr, 5);
    rst = 1'b1; in_sel = 3'd1; in_data = 8'hEE;
    #1 chk("mr_in_ready", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mr_out_valid", out_valid, 8'h00);
    chk("mr_ptr0", ptr, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("mr_out%0d", i + 1), outs[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux8_dispatch.md
Name: demux8_dispatch

Overview:
- 1-to-8 streaming dispatcher; the inverse of the 8-to-1 select path: one valid/ready input stream is steered to one of eight output channels.
- Destination comes from an explicit select or from an internal round-robin pointer.
- Each output channel has a one-entry holding register, so back-pressure on one channel does not block traffic bound for the others.
- Sits in front of replicated datapath lanes that are later recombined through the 8-way mux.

Parameters:
- WIDTH, 1, data width of the input and of each output channel.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  payload.
- in_valid  input  1  payload valid.
- in_ready  output  1  dispatcher can accept this cycle.
- in_sel  input  3  destination channel index when auto=0.
- auto  input  1  1 = destination is ptr; 0 = destination is in_sel.
- out1..out8  output  WIDTH each  channel payloads; channel index 0 maps to out1, index 7 maps to out8.
- out_valid  output  8  bit i set means out(i+1) holds valid data.
- out_ready  input  8  bit i set means the consumer of out(i+1) takes data this cycle.
- ptr  output  3  current round-robin pointer.

Behaviour:
- Index mapping matches the 8-way mux:
  - sel=3'd0 selects out1 and sel=3'd7 selects out8.
  - sel[2]=1 selects the upper half (out5..out8).
  - sel[1:0] selects within the half.
- Destination: d = auto ? ptr : in_sel. Evaluated combinationally every cycle.
- in_ready = !rst & (!out_valid[d] | out_ready[d]).
  - This is a combinational path from in_sel, auto and out_ready to in_ready.
  - Channels other than d never affect in_ready.
- Accept: the edge where in_valid & in_ready.
  - Next cycle: out(d+1) = in_data and out_valid[d] = 1.
  - Latency is 1 cycle.
- Drain: the edge where out_valid[i] & out_ready[i].
  - out_valid[i] clears next cycle, unless the same edge accepts a new word for channel i.
  - On simultaneous drain and refill, out_valid[i] stays 1 and the data register takes the new word (zero bubble).
- While out_valid[i]=1 and out_ready[i]=0: out(i+1) and out_valid[i] hold stable.
- Data registers load only on accept for their own channel; otherwise they hold.
- out_ready[i] asserted while out_valid[i]=0 has no effect.
- ptr:
  - Increments mod 8 on each accept with auto=1; wraps 7 to 0.
  - Holds when auto=0 or when there is no accept.
  - Changing auto mid-stream does not reset ptr.
- A stalled round-robin target (channel ptr full, not ready) blocks input even if other channels are empty. This is intended, to preserve strict rotation.
- Reset values (synchronous, next edge with rst=1):
  - out_valid = 8'h00, out1..out8 = 0, ptr = 3'd0.
  - in_ready = 0 for the whole time rst=1.
- Reset mid-operation: all pending channel data is discarded; no output handshake completes in a reset cycle.
- in_valid=0: no state change except drains.
- in_data and in_sel are don't-care when in_valid=0.

Test Plan:
- Reset then sel mode:
  - Stimulus: rst 2 cycles; auto=0; send 0xA5 with in_sel=0, then 0x3C with in_sel=7; all out_ready=0.
  - Response: out1=0xA5 and out8=0x3C, each one cycle after its accept; out_valid=8'h81; ptr=0.
- Back-pressure:
  - Stimulus: channel 2 full with out_ready[2]=0; drive in_sel=2, in_valid=1.
  - Response: in_ready=0 and out3 holds its old value.
  - Stimulus: drive in_sel=3.
  - Response: in_ready=1 and the word lands in out4.
- Simultaneous drain/refill:
  - Stimulus: channel 5 full; out_ready[5]=1 and a new word 0x11 sent to channel 5 on the same edge.
  - Response: out_valid[5] stays 1 and out6=0x11 next cycle.
  - Stimulus: sustain both for 8 words.
  - Response: 8 words delivered in 8 cycles with no bubbles.
- Round-robin wrap:
  - Stimulus: auto=1; all out_ready=1; stream 10 words 0..9.
  - Response: words land on out1..out8, then out1, out2; ptr sequence 0,1,...,7,0,1,2.
- Round-robin stall:
  - Stimulus: auto=1, ptr=4, out_valid[4]=1, out_ready[4]=0, other channels empty.
  - Response: in_ready=0 and ptr stays 4.
  - Stimulus: release out_ready[4].
  - Response: accept resumes and ptr advances to 5.
- Reset mid-stream:
  - Stimulus: channels 0, 3, 6 full with ptr=5; assert rst one cycle with in_valid=1.
  - Response: in_ready=0 during rst; next cycle out_valid=8'h00, ptr=0, all outputs 0.
